// File: rtl/mu0_ctrl_pkg.sv
// MU0 control unit shared types: opcodes, ALU function codes,
// FSM state encoding and the control word bundle.
package mu0_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] FS_PASSY = 2'b00;
  localparam logic [1:0] FS_ADD   = 2'b01;
  localparam logic [1:0] FS_INC   = 2'b10;
  localparam logic [1:0] FS_SUB   = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       acc_en;
    logic       ir_en;
    logic       rd;
    logic       wr;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [3:0] f);
    return f[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// MU0 control word decoder: combinational map of
// {state, opcode, flags, Mem_rdy} to mux selects, enables and strobes.
module mu0_ctrl_decode
  import mu0_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [3:0] i_f,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_rdy,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (1'b1)
      i_state == ST_FETCH: begin
        o_ctrl.rd     = 1'b1;
        o_ctrl.alu_fs = FS_INC;
        o_ctrl.ir_en  = i_rdy;
        o_ctrl.pc_en  = i_rdy;
      end
      i_state == ST_EXEC: begin
        o_ctrl.addr_sel = 1'b1;
        unique case (i_f)
          OP_LDA: begin
            o_ctrl.rd     = 1'b1;
            o_ctrl.alu_fs = FS_PASSY;
            o_ctrl.acc_en = i_rdy;
          end
          OP_STA: begin
            o_ctrl.wr    = 1'b1;
            o_ctrl.x_sel = 1'b1;
          end
          OP_ADD: begin
            o_ctrl.rd     = 1'b1;
            o_ctrl.x_sel  = 1'b1;
            o_ctrl.alu_fs = FS_ADD;
            o_ctrl.acc_en = i_rdy;
          end
          OP_SUB: begin
            o_ctrl.rd     = 1'b1;
            o_ctrl.x_sel  = 1'b1;
            o_ctrl.alu_fs = FS_SUB;
            o_ctrl.acc_en = i_rdy;
          end
          // jumps route IR through Y; only the PC load is conditional
          OP_JMP: begin
            o_ctrl.y_sel = 1'b1;
            o_ctrl.pc_en = 1'b1;
          end
          OP_JGE: begin
            o_ctrl.y_sel = 1'b1;
            o_ctrl.pc_en = ~i_n;
          end
          OP_JNE: begin
            o_ctrl.y_sel = 1'b1;
            o_ctrl.pc_en = ~i_z;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit top: state register, stall timeout and sticky error.
// Optional retired-instruction counter enabled by MU0_INSTR_COUNT_EN.
module mu0_control
  import mu0_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCW            = 5
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_rdy,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fs,
  output logic       PC_En,
  output logic       ACC_En,
  output logic       IR_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic       Err
`ifdef MU0_INSTR_COUNT_EN
  ,
  output logic [15:0] Instr_count
`endif
);

  state_e         r_state;
  state_e         w_next;
  logic [TCW-1:0] r_stall;
  logic [TCW-1:0] w_stall;
  logic           r_halted;
  logic           r_err;
  ctrl_t          w_c;
  logic           w_strobe;
  logic           w_to;
  logic           w_err;

  mu0_ctrl_decode u_dec (
    .i_state (r_state),
    .i_f     (F),
    .i_n     (N),
    .i_z     (Z),
    .i_rdy   (Mem_rdy),
    .o_ctrl  (w_c)
  );

  assign w_strobe = w_c.rd | w_c.wr;
  assign w_to = (TIMEOUT_CYCLES != 0)
             && (r_state != ST_HALT)
             && (r_stall == TCW'(TIMEOUT_CYCLES));

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state == ST_FETCH: begin
        if (Mem_rdy) w_next = ST_EXEC;
      end
      r_state == ST_EXEC: begin
        unique case (1'b1)
          F[3] || (F == OP_STP): w_next = ST_HALT;
          is_mem_op(F): begin
            if (Mem_rdy) w_next = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      default: ;
    endcase
    if (w_to) w_next = ST_HALT;
  end

  assign w_err = w_to || ((r_state == ST_EXEC) && F[3]);

  always_comb begin
    w_stall = r_stall;
    if (Mem_rdy || (w_next != r_state))
      w_stall = '0;
    else if (w_strobe)
      w_stall = r_stall + TCW'(1);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= ST_FETCH;
      r_stall  <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_stall  <= w_stall;
      r_halted <= (w_next == ST_HALT);
      if (w_err) r_err <= 1'b1;
    end
  end

  assign X_sel    = w_c.x_sel;
  assign Y_sel    = w_c.y_sel;
  assign Addr_sel = w_c.addr_sel;
  assign ALU_fs   = w_c.alu_fs;
  // reset low must kill strobes at once, not at the next edge
  assign PC_En    = w_c.pc_en  & ~w_to & nReset;
  assign ACC_En   = w_c.acc_en & ~w_to & nReset;
  assign IR_En    = w_c.ir_en  & ~w_to & nReset;
  assign Rd       = w_c.rd & nReset;
  assign Wr       = w_c.wr & nReset;
  assign Halted   = r_halted;
  assign Err      = r_err;

`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] r_icnt;
  logic        w_ret;

  assign w_ret = (r_state == ST_EXEC) && !w_to
              && ((w_next == ST_FETCH) || (F == OP_STP));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)    r_icnt <= '0;
    else if (w_ret) r_icnt <= r_icnt + 16'd1;
  end

  assign Instr_count = r_icnt;
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed steps then random instruction
// streams, checked against a behavioural instruction-level model.
module tb_mu0_control;

  localparam int TO = 4;

  logic       Clk = 1'b0;
  logic       nReset = 1'b1;
  logic [3:0] F = 4'd0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       Mem_rdy = 1'b0;
  logic       X_sel, Y_sel, Addr_sel;
  logic [1:0] ALU_fs;
  logic       PC_En, ACC_En, IR_En, Rd, Wr;
  logic       Halted, Err;
`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] Instr_count;
`endif

  mu0_control #(
    .TIMEOUT_CYCLES (TO),
    .TCW            (5)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .F        (F),
    .N        (N),
    .Z        (Z),
    .Mem_rdy  (Mem_rdy),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .Addr_sel (Addr_sel),
    .ALU_fs   (ALU_fs),
    .PC_En    (PC_En),
    .ACC_En   (ACC_En),
    .IR_En    (IR_En),
    .Rd       (Rd),
    .Wr       (Wr),
    .Halted   (Halted),
    .Err      (Err)
`ifdef MU0_INSTR_COUNT_EN
    ,
    .Instr_count (Instr_count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instruction-level model: where the machine is, and how long
  // the current memory access has been waiting
  bit m_halt, m_exec, m_err;
  int m_wait;
  int m_icnt;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected {X,Y,Addr,fs,PC,ACC,IR,Rd,Wr} for this cycle
  function automatic logic [9:0] expect_ctl();
    logic x, y, a, pc, acc, ir, rd, wr;
    logic [1:0] fs;
    bit to;
    {x, y, a, pc, acc, ir, rd, wr} = '0;
    fs = 2'd0;
    to = (m_wait == TO);
    if (m_halt) begin
    end else if (!m_exec) begin
      rd = 1; fs = 2'd2;
      ir = Mem_rdy && !to;
      pc = ir;
    end else begin
      a = 1;
      if (F < 4) begin
        rd = (F != 1);
        wr = (F == 1);
        x = (F != 0);
        fs = (F == 2) ? 2'd1 : (F == 3) ? 2'd3 : 2'd0;
        acc = Mem_rdy && (F != 1) && !to;
      end else if (F < 7) begin
        y = 1;
        pc = (F == 4) || (F == 5 && !N) || (F == 6 && !Z);
      end
    end
    return {x, y, a, fs, pc, acc, ir, rd, wr};
  endfunction

  task automatic model_reset();
    m_halt = 0; m_exec = 0; m_err = 0;
    m_wait = 0; m_icnt = 0;
  endtask

  task automatic step(input logic [3:0] f, input logic n,
                      input logic z, input logic r);
    logic [9:0] e;
    bit to, strobe, was_h, was_x;
    F = f; N = n; Z = z; Mem_rdy = r;
    #1;
    e = expect_ctl();
    chk("ctl", 16'({X_sel, Y_sel, Addr_sel, ALU_fs,
                    PC_En, ACC_En, IR_En, Rd, Wr}), 16'(e));
    chk("halted", 16'(Halted), 16'(m_halt));
    chk("err", 16'(Err), 16'(m_err));
`ifdef MU0_INSTR_COUNT_EN
    chk("icnt", Instr_count, 16'(m_icnt));
`endif
    to = (m_wait == TO);
    strobe = e[1] | e[0];
    was_h = m_halt; was_x = m_exec;
    if (m_halt) begin
    end else if (to) begin
      m_halt = 1; m_err = 1;
    end else if (!m_exec) begin
      if (r) m_exec = 1;
    end else if (f >= 8) begin
      m_halt = 1; m_err = 1;
    end else if (f == 7) begin
      m_halt = 1; m_icnt = (m_icnt + 1) % 65536;
    end else if (f >= 4 || r) begin
      m_exec = 0; m_icnt = (m_icnt + 1) % 65536;
    end
    if (r || was_h != m_halt || was_x != m_exec) m_wait = 0;
    else if (strobe) m_wait++;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    #1;
    chk("rst_strobes", 16'({PC_En, ACC_En, IR_En, Rd, Wr}), 16'd0);
    chk("rst_halted", 16'(Halted), 16'd0);
    chk("rst_err", 16'(Err), 16'd0);
    @(posedge Clk);
    #3;
    nReset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] cur_f;
    int hcnt;
    model_reset();
    #2;
    do_reset();

    // LDA with zero wait states alternates FETCH/EXEC
    repeat (6) step(4'd0, 0, 0, 1);

    // conditional jumps
    step(4'd5, 1, 0, 1); step(4'd5, 1, 0, 1);
    step(4'd5, 0, 0, 1); step(4'd5, 0, 0, 1);
    step(4'd6, 0, 1, 1); step(4'd6, 0, 1, 1);
    step(4'd6, 0, 0, 1); step(4'd6, 0, 0, 1);

    // ADD with three wait states
    step(4'd2, 0, 0, 1);
    repeat (3) step(4'd2, 0, 0, 0);
    step(4'd2, 0, 0, 1);
    step(4'd0, 0, 0, 1);
    step(4'd0, 0, 0, 1);

    // STP halts cleanly and stays there
    step(4'd7, 0, 0, 1);
    repeat (12) step(4'd7, 0, 0, 1);
    do_reset();

    // illegal opcode
    step(4'd9, 0, 0, 1);
    repeat (3) step(4'd9, 0, 0, 1);
    do_reset();

    // fetch stall timeout
    repeat (8) step(4'd0, 0, 0, 0);
    chk("to_halted", 16'(Halted), 16'd1);
    do_reset();

    // async reset mid STA wait
    step(4'd1, 0, 0, 1);
    step(4'd1, 0, 0, 0);
    step(4'd1, 0, 0, 0);
    chk("sta_wr", 16'(Wr), 16'd1);
    #1 nReset = 1'b0;
    #1 chk("async_wr", 16'(Wr), 16'd0);
    do_reset();
    step(4'd1, 0, 0, 1);

    // random instruction streams
    cur_f = 4'd0;
    hcnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (m_halt) begin
        hcnt++;
        if (hcnt > 2) begin
          do_reset();
          hcnt = 0;
        end
      end
      if (!m_exec) begin
        if ($urandom_range(0, 29) == 0)
          cur_f = 4'($urandom_range(8, 15));
        else if ($urandom_range(0, 19) == 0)
          cur_f = 4'd7;
        else
          cur_f = 4'($urandom_range(0, 6));
      end
      step(cur_f, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
